// File: rtl/hhmm_level_ctrl_if.sv
// Parent/level-side signal bundle for the HHMM level sequencer.
// The master side is the parent plus the level it drives; the slave side is the sequencer.
interface hhmm_level_ctrl_if #(
  parameter int VW = 8
) ();
  logic          EN;
  logic          S0;
  logic          S1;
  logic          T;
  logic          T_SUB;
  logic [1:0]    BV;
  logic [1:0]    SUB_EN;
  logic          SEL;
  logic          DONE;
  logic          TIMEOUT;
  logic [VW-1:0] VISITS;

  modport master (
    output EN, S0, S1, T, T_SUB,
    input  BV, SUB_EN, SEL, DONE, TIMEOUT, VISITS
  );

  modport slave (
    input  EN, S0, S1, T, T_SUB,
    output BV, SUB_EN, SEL, DONE, TIMEOUT, VISITS
  );
endinterface

// File: rtl/hhmm_level_ctrl.sv
// Sequencer for a size-2 HHMM level: init, stable-decision search, sub-level hand-off,
// and termination reporting. All outputs are registered from the next-state logic.
module hhmm_level_ctrl #(
  parameter int INIT_CYC   = 2,
  parameter int STABLE_CYC = 3,
  parameter int SEARCH_MAX = 1023,
  parameter int CW         = 10,
  parameter int VW         = 8,
  parameter bit HAS_SUB    = 1'b1
) (
  input  logic               CLK,
  input  logic               RSTn,
  hhmm_level_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT      = 3'd1,
    ST_SEARCH    = 3'd2,
    ST_SUB       = 3'd3,
    ST_TERM      = 3'd4,
    ST_DONE_WAIT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAND_NONE = 2'd0,
    CAND_S0   = 2'd1,
    CAND_S1   = 2'd2,
    CAND_TERM = 2'd3
  } cand_t;

  localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] INIT_LAST   = CW'(INIT_CYC - 1);
  localparam logic [CW-1:0] STABLE_LIM  = CW'(STABLE_CYC);
  localparam logic [CW-1:0] SEARCH_LIM  = CW'(SEARCH_MAX);
  localparam logic [VW-1:0] VIS_ONE     = VW'(1);
  localparam logic [VW-1:0] VIS_MAX     = {VW{1'b1}};

  state_t        state_r,     state_nxt_s;
  cand_t         prev_cand_r, prev_nxt_s, cand_s;
  logic [CW-1:0] cnt_r,       cnt_nxt_s;
  logic [CW-1:0] stab_r,      stab_nxt_s, stab_inc_s;
  logic [1:0]    bv_r,        bv_nxt_s;
  logic [1:0]    sub_en_r,    sub_en_nxt_s;
  logic          sel_r,       sel_nxt_s;
  logic          done_r,      done_nxt_s;
  logic          timeout_r,   timeout_nxt_s;
  logic [VW-1:0] visits_r,    visits_nxt_s;
  logic          confirm_s;

  // Classify this cycle's level outputs; terminate outranks a decision, S0=S1=1 is no candidate.
  always_comb begin
    cand_s = CAND_NONE;
    if (bus.T) begin
      cand_s = CAND_TERM;
    end else if (bus.S0 ^ bus.S1) begin
      cand_s = bus.S1 ? CAND_S1 : CAND_S0;
    end else begin
      cand_s = CAND_NONE;
    end
  end

  // Run length of the current candidate and whether it has just become stable.
  always_comb begin
    stab_inc_s = CNT_ZERO;
    if (cand_s == CAND_NONE) begin
      stab_inc_s = CNT_ZERO;
    end else if (cand_s == prev_cand_r) begin
      stab_inc_s = stab_r + CNT_ONE;
    end else begin
      stab_inc_s = CNT_ONE;
    end
    confirm_s = (cand_s != CAND_NONE) && (stab_inc_s == STABLE_LIM);
  end

  // Next-state and next-output logic; a dropped EN overrides every other event.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    stab_nxt_s    = stab_r;
    prev_nxt_s    = prev_cand_r;
    sub_en_nxt_s  = 2'b00;
    sel_nxt_s     = sel_r;
    timeout_nxt_s = timeout_r;
    visits_nxt_s  = visits_r;
    if (!bus.EN) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s   = ST_INIT;
          cnt_nxt_s     = CNT_ZERO;
          visits_nxt_s  = {VW{1'b0}};
          timeout_nxt_s = 1'b0;
        end
        ST_INIT: begin
          if (cnt_r == INIT_LAST) begin
            state_nxt_s = ST_SEARCH;
            cnt_nxt_s   = CNT_ZERO;
            stab_nxt_s  = CNT_ZERO;
            prev_nxt_s  = CAND_NONE;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_SEARCH: begin
          cnt_nxt_s  = cnt_r + CNT_ONE;
          stab_nxt_s = stab_inc_s;
          prev_nxt_s = cand_s;
          if (confirm_s && (cand_s == CAND_TERM)) begin
            state_nxt_s = ST_TERM;
          end else if (confirm_s) begin
            state_nxt_s  = ST_SUB;
            sel_nxt_s    = (cand_s == CAND_S1);
            sub_en_nxt_s = (cand_s == CAND_S1) ? 2'b10 : 2'b01;
            visits_nxt_s = (visits_r == VIS_MAX) ? visits_r : visits_r + VIS_ONE;
          end else if ((cnt_r + CNT_ONE) == SEARCH_LIM) begin
            state_nxt_s   = ST_TERM;
            timeout_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_SEARCH;
          end
        end
        ST_SUB: begin
          // A leaf level has nothing below it, so SUB is a single pass-through cycle.
          if (!HAS_SUB || bus.T_SUB) begin
            state_nxt_s = ST_SEARCH;
            cnt_nxt_s   = CNT_ZERO;
            stab_nxt_s  = CNT_ZERO;
            prev_nxt_s  = CAND_NONE;
          end else begin
            sub_en_nxt_s = sub_en_r;
          end
        end
        ST_TERM: begin
          state_nxt_s = ST_DONE_WAIT;
        end
        ST_DONE_WAIT: begin
          state_nxt_s = ST_DONE_WAIT;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end

    done_nxt_s = (state_nxt_s == ST_TERM);
    case (state_nxt_s)
      ST_INIT:   bv_nxt_s = 2'd3;
      ST_SEARCH: bv_nxt_s = 2'd1;
      ST_SUB:    bv_nxt_s = 2'd2;
      default:   bv_nxt_s = 2'd0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r     <= ST_IDLE;
      prev_cand_r <= CAND_NONE;
      cnt_r       <= CNT_ZERO;
      stab_r      <= CNT_ZERO;
      bv_r        <= 2'd0;
      sub_en_r    <= 2'b00;
      sel_r       <= 1'b0;
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
      visits_r    <= {VW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      prev_cand_r <= prev_nxt_s;
      cnt_r       <= cnt_nxt_s;
      stab_r      <= stab_nxt_s;
      bv_r        <= bv_nxt_s;
      sub_en_r    <= sub_en_nxt_s;
      sel_r       <= sel_nxt_s;
      done_r      <= done_nxt_s;
      timeout_r   <= timeout_nxt_s;
      visits_r    <= visits_nxt_s;
    end
  end

  assign bus.BV      = bv_r;
  assign bus.SUB_EN  = sub_en_r;
  assign bus.SEL     = sel_r;
  assign bus.DONE    = done_r;
  assign bus.TIMEOUT = timeout_r;
  assign bus.VISITS  = visits_r;

endmodule

// File: doc/hhmm_level_ctrl.md
Name: hhmm_level_ctrl

Overview:
Sequencer that sits directly upstream of a size-2 HHMM level and drives its 2-bit BV mode code (0 sleep, 1 search, 2 sub-active, 3 init). It watches the level's S0/S1/T outputs, confirms a stochastic decision once it has been stable, and latches the chosen state. It then hands control to the sub-level under that state and resumes search when the sub-level terminates. When the level's own terminate is confirmed, it reports completion to the parent.

Parameters:
INIT_CYC, 2, cycles BV is held at 3 (init) after activation; minimum 1
STABLE_CYC, 3, consecutive identical cycles required to confirm a decision or a terminate; minimum 1
SEARCH_MAX, 1023, search cycles without confirmation before timeout; must be < 2^CW
CW, 10, width of the internal cycle counter
VW, 8, width of the transition counter VISITS
HAS_SUB, 1, 1 = sub-levels exist; 0 = leaf level, SUB lasts exactly one cycle

Ports:
CLK  in  1  clock, all state updates on posedge
RSTn  in  1  asynchronous active-low reset
EN  in  1  level activation from the parent (parent state selecting this level is active)
S0  in  1  level state-0 output
S1  in  1  level state-1 output
T  in  1  level terminate output
T_SUB  in  1  terminate from the currently enabled sub-level
BV  out  2  mode code to the level
SUB_EN  out  2  one-hot enable for the sub-level under S0 (bit 0) or S1 (bit 1)
SEL  out  1  latched decided state, valid while in SUB
DONE  out  1  one-cycle pulse when the level terminates normally
TIMEOUT  out  1  sticky flag, set when a search times out
VISITS  out  VW  saturating count of confirmed decisions since activation

Behaviour:
- Reset (RSTn=0, asynchronous): state IDLE; BV=0, SUB_EN=0, SEL=0, DONE=0, TIMEOUT=0, VISITS=0, counters=0.
- All outputs are registered. The value of BV in a cycle reflects the state entered on that cycle's edge.
- IDLE (BV=0): when EN=1, go to INIT, clear VISITS and TIMEOUT, and clear the counter.
- INIT (BV=3): stay for INIT_CYC cycles, then go to SEARCH with the counter cleared.
- SEARCH (BV=1):
  - Candidate per cycle: T=1 gives TERM-candidate; otherwise S0^S1=1 gives a decision candidate with sel=S1; otherwise none.
  - T has priority over S0/S1. S0=S1=1 counts as no candidate.
  - The stability counter increments while the candidate is unchanged from the previous cycle. It restarts at 1 on a change and at 0 when there is no candidate.
  - When the stability count reaches STABLE_CYC:
    - Decision: latch SEL, set SUB_EN bit SEL, increment VISITS (saturating at 2^VW-1), go to SUB.
    - Terminate: go to TERM.
  - The search counter increments every SEARCH cycle. If it reaches SEARCH_MAX with no confirmation, set TIMEOUT and go to TERM. If confirmation and timeout occur in the same cycle, the confirmation wins.
- SUB (BV=2, SUB_EN one-hot):
  - HAS_SUB=1: wait for T_SUB=1, then clear SUB_EN, clear both counters, and return to SEARCH.
  - HAS_SUB=0: return to SEARCH after exactly one cycle; T_SUB is ignored.
- TERM (BV=0): DONE=1 for exactly one cycle, then go to DONE_WAIT.
- DONE_WAIT (BV=0): wait for EN=0, then go to IDLE. A terminated level is not restarted until the parent deactivates it.
- Abort: EN=0 in any state other than IDLE sends the FSM to IDLE on the next edge with BV=0 and SUB_EN=0 and no DONE pulse. TIMEOUT and VISITS hold their values until the next activation.
- Simultaneous events: EN falling takes priority over T_SUB and over confirmation. T_SUB while not in SUB is ignored.
- At most one SUB_EN bit is ever set. SUB_EN is nonzero only in SUB.

Test Plan:
- Reset and idle: hold RSTn=0 with EN=1, then release with EN=0 for 10 cycles -> BV=0, SUB_EN=0, DONE=0, VISITS=0 throughout.
- Decision: EN=1, then drive S0=1, S1=0, T=0 for 3 cycles after INIT -> BV sequence 3,3,1,1,1,2, SUB_EN=01, SEL=0, VISITS=1. Then pulse T_SUB for 1 cycle -> BV=1, SUB_EN=00.
- Unstable candidate: in SEARCH, alternate S0/S1 each cycle for 20 cycles, then S1=1 steady -> no SUB before the steady run; SUB entered 3 cycles into the run with SUB_EN=10. Also check that S0=S1=1 for 5 cycles never confirms.
- Terminate: T=1 for 3 cycles in SEARCH (S0=1 as well) -> TERM chosen over the decision, a single DONE pulse, BV=0; with EN held at 1, the FSM stays idle with no re-INIT until EN toggles 0 then 1.
- Timeout: SEARCH_MAX=16, no candidate -> TIMEOUT=1 after 16 SEARCH cycles, one DONE pulse, TIMEOUT sticky until the next activation.
- Abort and leaf mode: drop EN while in SUB together with T_SUB=1 -> IDLE next cycle, no DONE. With HAS_SUB=0, a confirmed decision gives exactly one BV=2 cycle and then BV=1.
